u_mesh_center_select: RTL and testbench

- Per-router multicast helper implementing one split step of U-mesh recursive-halving multicast.
- Takes the packet's destination sets at three levels and picks the active set: level 2, else level 1, else the full multicast set.
- Outputs the "center" node that takes over the upper half of the active set, plus the destinations that center becomes responsible for (doc).
- Sits beside the router's routing-computation stage; outputs are registered.

---
 rtl/u_mesh_center_select.sv | 88 ++++++++
 tb/tb_u_mesh_center_select.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/u_mesh_center_select.sv
// One recursive-halving split step for U-mesh multicast: picks the active
// destination set, its center node, and the destinations delegated to it.
`ifndef MADDR
`define MADDR 15
`endif

module u_mesh_center_select #(
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0,
  parameter int XDIM    = 4,
  parameter int YDIM    = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              in_valid,
  input  logic [`MADDR:0]   mult_dst,
  input  logic [`MADDR:0]   l1_dst,
  input  logic [`MADDR:0]   l2_dst,
  output logic              out_valid,
  output logic [4:0]        l2_center,
  output logic [`MADDR:0]   doc
);

  localparam int W      = `MADDR + 1;
  localparam int OWN_ID = MY_YPOS * XDIM + MY_XPOS;
  localparam logic [W-1:0] OWN_BIT = W'(1) << OWN_ID;

  if (XDIM * YDIM != W || W > 31) begin : g_bad_dims
    $error("XDIM*YDIM must equal MADDR+1 and be at most 31");
  end

  logic [W-1:0] sel_set;
  logic [W-1:0] act_set;
  logic [5:0]   k;
  logic [5:0]   half;
  logic [5:0]   rank;
  logic         found;
  logic [4:0]   center_c;
  logic [W-1:0] doc_c;

  // Priority uses the raw inputs; the own bit is stripped only afterwards.
  always_comb begin
    sel_set = (l2_dst != '0) ? l2_dst : (l1_dst != '0) ? l1_dst : mult_dst;
    act_set = sel_set & ~OWN_BIT;
  end

  always_comb begin
    k = '0;
    for (int unsigned i = 0; i < W; i++) begin
      k = k + {5'b0, act_set[i]};
    end
    half = k >> 1;
  end

  // Center is the member at zero-based rank floor(k/2); every member above it is delegated.
  always_comb begin
    rank     = '0;
    found    = 1'b0;
    center_c = 5'd31;
    doc_c    = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (act_set[i]) begin
        if (found) begin
          doc_c[i] = 1'b1;
        end else if (rank == half) begin
          center_c = i[4:0];
          found    = 1'b1;
        end
        rank = rank + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      out_valid <= 1'b0;
      l2_center <= 5'd31;
      doc       <= '0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      l2_center <= center_c;
      doc       <= doc_c;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_u_mesh_center_select.sv
// Scoreboard bench for u_mesh_center_select on a 4x4 mesh with own node 4.
`ifndef MADDR
`define MADDR 15
`endif

module tb_u_mesh_center_select;

  localparam int W   = `MADDR + 1;
  localparam int OWN = 1 * 4 + 0;

  typedef struct packed {
    logic [4:0]   c;
    logic [W-1:0] d;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_ = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] mult_dst = '0;
  logic [W-1:0] l1_dst = '0;
  logic [W-1:0] l2_dst = '0;
  logic         out_valid;
  logic [4:0]   l2_center;
  logic [W-1:0] doc;

  res_t sb[$];
  res_t held;
  int   errors = 0;
  int   checks = 0;

  u_mesh_center_select #(.MY_XPOS(0), .MY_YPOS(1), .XDIM(4), .YDIM(4)) dut (
    .clk(clk), .rst_(rst_), .in_valid(in_valid),
    .mult_dst(mult_dst), .l1_dst(l1_dst), .l2_dst(l2_dst),
    .out_valid(out_valid), .l2_center(l2_center), .doc(doc)
  );

  always #5 clk = ~clk;

  // Reference: build the ordered member list, take the middle-upper entry.
  function automatic res_t model(input logic [W-1:0] m, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    logic [W-1:0] s;
    int list[$];
    res_t r;
    s = (b != 0) ? b : ((a != 0) ? a : m);
    s[OWN] = 1'b0;
    for (int i = 0; i < W; i++) if (s[i]) list.push_back(i);
    r.c = 5'd31;
    r.d = '0;
    if (list.size() > 0) begin
      r.c = 5'(list[list.size() / 2]);
      for (int j = list.size() / 2 + 1; j < list.size(); j++) r.d[list[j]] = 1'b1;
    end
    return r;
  endfunction

  task automatic step(input logic r, input logic v, input logic [W-1:0] m,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    @(negedge clk);
    rst_ = r; in_valid = v; mult_dst = m; l1_dst = a; l2_dst = b;
    if (r && v) sb.push_back(model(m, a, b));
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== (r && v)) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", out_valid, r && v);
    end
    if (!r) begin
      e.c = 5'd31; e.d = '0;
    end else if (v) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: empty when result expected");
        e = held;
      end else begin
        e = sb.pop_front();
      end
    end else begin
      e = held;
    end
    checks++;
    if (l2_center !== e.c || doc !== e.d) begin
      errors++;
      $display("FAIL result: got center=%0d doc=%h expected center=%0d doc=%h",
               l2_center, doc, e.c, e.d);
    end
    held = e;
  endtask

  task automatic expect_const(input string name, input logic [4:0] c, input logic [W-1:0] d);
    checks++;
    if (l2_center !== c || doc !== d) begin
      errors++;
      $display("FAIL %s: got center=%0d doc=%h expected center=%0d doc=%h",
               name, l2_center, doc, c, d);
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 16'hFFFF, '0, '0);
    expect_const("reset_state", 5'd31, 16'h0000);
  endtask

  task automatic test_full_set();
    step(1'b1, 1'b1, 16'b1010_1101_1110_1001, '0, '0);
    expect_const("case1_mult", 5'd8, 16'hAC00);
  endtask

  task automatic test_priority();
    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0013);
    expect_const("case2_l2_own_mask", 5'd1, 16'h0000);
    step(1'b1, 1'b1, 16'hFFFF, 16'h0F00, 16'h0000);
    expect_const("case3_l1", 5'd10, 16'h0800);
    step(1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'h0010);
    expect_const("l2_own_only", 5'd31, 16'h0000);
  endtask

  task automatic test_empty();
    step(1'b1, 1'b1, '0, '0, '0);
    expect_const("all_zero", 5'd31, 16'h0000);
    step(1'b1, 1'b1, 16'h0010, '0, '0);
    expect_const("own_only", 5'd31, 16'h0000);
    step(1'b1, 1'b1, 16'h8000, '0, '0);
    expect_const("single", 5'd15, 16'h0000);
  endtask

  task automatic test_reset_midstream();
    step(1'b1, 1'b1, 16'b1010_1101_1110_1001, '0, '0);
    step(1'b0, 1'b1, 16'b1010_1101_1110_1001, '0, '0);
    expect_const("mid_reset", 5'd31, 16'h0000);
    step(1'b1, 1'b1, 16'hFFFF, 16'h0F00, 16'h0000);
    expect_const("after_release", 5'd10, 16'h0800);
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, 16'b1010_1101_1110_1001, '0, '0);
    expect_const("b2b_1", 5'd8, 16'hAC00);
    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0013);
    expect_const("b2b_2", 5'd1, 16'h0000);
    step(1'b1, 1'b1, 16'hFFFF, 16'h0F00, 16'h0000);
    expect_const("b2b_3", 5'd10, 16'h0800);
    step(1'b1, 1'b0, 16'h1234, 16'h0000, 16'h0000);
    expect_const("hold", 5'd10, 16'h0800);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h00F0);
    expect_const("hold2", 5'd10, 16'h0800);
  endtask

  task automatic test_random();
    logic [W-1:0] m, a, b;
    for (int n = 0; n < 40; n++) begin
      m = W'($urandom);
      a = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom);
      b = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      step(1'b1, ($urandom_range(0, 3) != 0), m, a, b);
    end
  endtask

  initial begin
    held.c = 5'd31;
    held.d = '0;
    test_reset();
    test_full_set();
    test_priority();
    test_empty();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
